// File: rtl/axi4_b_buffer_pkg.sv
// Shared definitions for the write-response return buffer: AXI response
// encodings and the response-code remap applied when an entry is stored.
// No ports; imported by axi4_b_buffer.
package axi4_b_buffer_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // DECERR is reported to the master as SLVERR; every other code is kept.
    function automatic logic [1:0] decerr_to_slverr(input logic [1:0] resp);
        logic [1:0] mapped;
        mapped = resp;
        case (resp)
            RESP_OKAY, RESP_EXOKAY, RESP_SLVERR: mapped = resp;
            RESP_DECERR:                         mapped = RESP_SLVERR;
            default:                             mapped = resp;
        endcase
        return mapped;
    endfunction

endpackage

// File: rtl/axi4_b_delay_fifo.sv
// Purpose: in-order data FIFO whose head is released only once it has aged LAT cycles.
// Latency: push at edge E -> pop_vld in the cycle after edge E+LAT (LAT=0: next cycle).
// Backpressure: push_rdy is registered (low when full next cycle); pop_vld/pop_dat hold until pop_rdy.
// Ports: core_clk/arst_n; push_vld/push_rdy/push_dat from the producer;
//        pop_vld/pop_rdy/pop_dat to the consumer (pop_dat holds the last popped word when not valid).
module axi4_b_delay_fifo #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 4,
    parameter int LAT          = 5
) (
    input  logic                  core_clk,
    input  logic                  arst_n,
    input  logic                  push_vld,
    output logic                  push_rdy,
    input  logic [DATA_WIDTH-1:0] push_dat,
    output logic                  pop_vld,
    input  logic                  pop_rdy,
    output logic [DATA_WIDTH-1:0] pop_dat
);

    localparam int PW = $clog2(BUFFER_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [AW-1:0] LAT_A  = AW'(LAT);
    localparam logic [CW-1:0] FULL_C = CW'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [AW-1:0]         age_q [BUFFER_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  rdy_q;
    logic [DATA_WIDTH-1:0] last_q;
    logic                  push_fire;
    logic                  pop_fire;

    assign push_rdy  = rdy_q;
    assign push_fire = push_vld & rdy_q;
    assign pop_vld   = (count_q != '0) && (age_q[rd_ptr_q] == LAT_A);
    assign pop_fire  = pop_vld & pop_rdy;
    // Head is shown only while valid; otherwise the last delivered word is held.
    assign pop_dat   = pop_vld ? mem_q[rd_ptr_q] : last_q;

    always_comb begin
        count_nxt = count_q + CW'(push_fire) - CW'(pop_fire);
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            count_q <= count_nxt;
            // Ready looks only at the next occupancy, so the consumer's
            // ready never reaches push_rdy combinationally.
            rdy_q   <= (count_nxt != FULL_C);
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    // Free slots age too; harmless because a push always restarts its slot at 0.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                if (push_fire && (wr_ptr_q == PW'(i))) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != LAT_A) begin
                    age_q[i] <= age_q[i] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/axi4_b_buffer.sv
// Purpose: AXI4 B-channel return buffer holding every write response LAT cycles, in order.
// Latency: response handshaken in cycle C is presented to the master in cycle C+LAT+1.
// Backpressure: m_axi4_bready is registered, low while full; s_axi4_b* stable until s_axi4_bready.
// Ports: axi4_aclk/axi4_arstn; m_axi4_b* from the slave; s_axi4_b* to the master.
// Build option: AXI4_B_BUF_DECERR_TO_SLVERR_EN stores DECERR responses as SLVERR.
module axi4_b_buffer
    import axi4_b_buffer_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int LAT            = 5,
    parameter int BUFFER_DEPTH   = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [1:0]                m_axi4_bresp,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
    input  logic                      m_axi4_bvalid,
    output logic                      m_axi4_bready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]                s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
    output logic                      s_axi4_bvalid,
    input  logic                      s_axi4_bready
);

    localparam int ENTRY_W = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;

    logic [1:0]         push_resp;
    logic [ENTRY_W-1:0] push_dat;
    logic [ENTRY_W-1:0] pop_dat;

`ifdef AXI4_B_BUF_DECERR_TO_SLVERR_EN
    assign push_resp = decerr_to_slverr(m_axi4_bresp);
`else
    assign push_resp = m_axi4_bresp;
`endif

    assign push_dat = {m_axi4_bid, push_resp, m_axi4_buser};
    assign {s_axi4_bid, s_axi4_bresp, s_axi4_buser} = pop_dat;

    axi4_b_delay_fifo #(
        .DATA_WIDTH   (ENTRY_W),
        .BUFFER_DEPTH (BUFFER_DEPTH),
        .LAT          (LAT)
    ) u_delay_fifo (
        .core_clk (axi4_aclk),
        .arst_n   (axi4_arstn),
        .push_vld (m_axi4_bvalid),
        .push_rdy (m_axi4_bready),
        .push_dat (push_dat),
        .pop_vld  (s_axi4_bvalid),
        .pop_rdy  (s_axi4_bready),
        .pop_dat  (pop_dat)
    );

endmodule

// File: tb/tb_axi4_b_buffer.sv
// Purpose: randomized scoreboard bench for axi4_b_buffer against a queue-based timing model.
// Latency: each accepted response is due LAT+1 cycles after its handshake cycle, in order.
// Backpressure: master ready randomized and forced low to fill the buffer; reset asserted mid-flight.
module tb_axi4_b_buffer;

    localparam int LAT   = 5;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
        logic [3:0] user;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic [3:0] m_bid = '0;
    logic [1:0] m_bresp = '0;
    logic [3:0] m_buser = '0;
    logic       m_bvalid = 1'b0;
    logic       m_bready;
    logic [3:0] s_bid;
    logic [1:0] s_bresp;
    logic [3:0] s_buser;
    logic       s_bvalid;
    logic       s_bready = 1'b0;

    exp_t       sb[$];
    int         cyc = 0;
    int         since = 0;
    int         push_cyc = -1;
    logic [9:0] last_exp = '0;
    int         n_cmp = 0;
    int         n_err = 0;

    bit         pn;
    int         held;
    bit         ev;

    axi4_b_buffer #(
        .AXI_ID_WIDTH   (4),
        .AXI_USER_WIDTH (4),
        .LAT            (LAT),
        .BUFFER_DEPTH   (DEPTH)
    ) dut (
        .axi4_aclk     (clk),
        .axi4_arstn    (arstn),
        .m_axi4_bid    (m_bid),
        .m_axi4_bresp  (m_bresp),
        .m_axi4_buser  (m_buser),
        .m_axi4_bvalid (m_bvalid),
        .m_axi4_bready (m_bready),
        .s_axi4_bid    (s_bid),
        .s_axi4_bresp  (s_bresp),
        .s_axi4_buser  (s_buser),
        .s_axi4_bvalid (s_bvalid),
        .s_axi4_bready (s_bready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) since <= 0;
        else        since <= since + 1;
    end

    function automatic logic [1:0] exp_resp(input logic [1:0] r);
`ifdef AXI4_B_BUF_DECERR_TO_SLVERR_EN
        return (r == 2'b11) ? 2'b10 : r;
`else
        return r;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // One stimulus cycle; an accepted response is queued with its due cycle.
    task automatic drive(input bit v, input logic [3:0] id, input logic [1:0] resp,
                         input logic [3:0] user, input bit rdy);
        exp_t e;
        @(posedge clk);
        #1;
        m_bvalid = v;
        m_bid    = id;
        m_bresp  = resp;
        m_buser  = user;
        s_bready = rdy;
        if (v && arstn && since > 0 && sb.size() < DEPTH) begin
            e.id   = id;
            e.resp = exp_resp(resp);
            e.user = user;
            e.due  = cyc + LAT + 1;
            sb.push_back(e);
            push_cyc = cyc;
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        arstn    = 1'b0;
        m_bvalid = 1'b0;
        sb.delete();
        last_exp = '0;
        repeat (hold) @(posedge clk);
        #1;
        arstn = 1'b1;
    endtask

    // Monitor: compares DUT outputs with the model each cycle, pops on handshake.
    always @(negedge clk) begin
        pn   = (push_cyc == cyc);
        held = sb.size() - (pn ? 1 : 0);
        ev   = arstn && (held > 0) && (cyc >= sb[0].due);
        chk("bvalid", 32'(s_bvalid), 32'(ev));
        chk("m_bready", 32'(m_bready), 32'(arstn && since > 0 && held < DEPTH));
        if (ev) begin
            chk("payload", 32'({s_bid, s_bresp, s_buser}),
                32'({sb[0].id, sb[0].resp, sb[0].user}));
            if (s_bready) begin
                last_exp = {sb[0].id, sb[0].resp, sb[0].user};
                void'(sb.pop_front());
            end
        end else if (held == 0) begin
            chk("hold_payload", 32'({s_bid, s_bresp, s_buser}), 32'(last_exp));
        end
    end

    initial begin
        // Reset state checked by the monitor while reset is held.
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b1;
        repeat (3) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        // Single response, id 3 OKAY.
        drive(1'b1, 4'h3, 2'b00, 4'h5, 1'b1);
        repeat (10) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        // Four back-to-back responses drained back-to-back.
        for (int i = 0; i < 4; i++) drive(1'b1, 4'(i), 2'(i), 4'(i + 8), 1'b1);
        repeat (12) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        // Fill while the master stalls; the fifth response must be refused.
        for (int i = 0; i < 4; i++) drive(1'b1, 4'(i), 2'b01, 4'(i), 1'b0);
        repeat (12) drive(1'b1, 4'h4, 2'b10, 4'hf, 1'b0);
        repeat (10) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        // DECERR response.
        drive(1'b1, 4'h9, 2'b11, 4'h1, 1'b1);
        repeat (10) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        // Random traffic with varying master backpressure.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 60, 4'($urandom), 2'($urandom), 4'($urandom),
                  $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 80 : 25));
        end
        repeat (12) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        // Reset with three responses buffered; none may reappear afterwards.
        for (int i = 0; i < 3; i++) drive(1'b1, 4'(i + 5), 2'b00, 4'h2, 1'b0);
        repeat (2) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b0);
        do_reset(3);
        repeat (20) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        // Traffic after reset.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 99) < 70, 4'($urandom), 2'($urandom), 4'($urandom),
                  $urandom_range(0, 99) < 60);
        end
        repeat (15) drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b1);

        @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
